md_unit: RTL and testbench

Parametrised iterative multiply/divide unit with architectural HI/LO registers. It adds MIPS mult/multu/div/divu/mthi/mtlo/mfhi/mflo support to the pipelined CPU. The unit sits in the EX stage: ID_EX issues operations, and busy feeds the hazard/stall logic so that a dependent mfhi/mflo or a second md op holds the pipeline. HI/LO read values go to the EX result mux.

---
 rtl/md_unit.sv | 208 ++++++++++++++++++++
 tb/tb_md_unit.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// -----------------------------------------------------------------------------
// md_unit -- iterative multiply/divide unit with architectural HI/LO registers.
//
// Executes MIPS mult/multu/div/divu with one radix-2 step per cycle, and
// mthi/mtlo through the mt_we port. The unit lives in the EX stage: busy
// drives the hazard logic so that mfhi/mflo or a second md op stalls while an
// operation is in flight.
//
// Ports
//   clk      system clock, all state changes on the rising edge
//   reset    synchronous, active-high reset
//   start    issue request (ignored while busy or when flush is high)
//   op       00 mult, 01 multu, 10 div, 11 divu
//   a, b     rs / rt operands
//   flush    cancels the in-flight op and any same-cycle start
//   mt_we    bit1 = mthi write, bit0 = mtlo write (honoured only while idle)
//   mt_data  data for mthi/mtlo
//   busy     operation in flight
//   done     one-cycle pulse: HI/LO were just updated by a completed op
//   hi, lo   HI / LO registers
//
// Latency: start in cycle 0, busy in cycles 1..XLEN+1, done in cycle XLEN+2.
// -----------------------------------------------------------------------------
module md_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  input  logic [1:0]      mt_we,
  input  logic [XLEN-1:0] mt_data,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt;

  // acc holds the upper product half (multiply) or the partial remainder
  // (divide); qr holds the multiplier / quotient as it shifts through.
  logic [XLEN-1:0]   acc;
  logic [XLEN-1:0]   qr;
  logic [XLEN-1:0]   opnd_b;   // multiplicand or divisor magnitude
  logic              is_div;
  logic              neg_q;    // product / quotient must be negated
  logic              neg_r;    // remainder must be negated (dividend < 0)
  logic              b_zero;   // divide by zero: keep the all-ones quotient

  // ---------------------------------------------------------------------------
  // Issue decode
  // ---------------------------------------------------------------------------
  logic            accept;
  logic            op_signed;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;

  assign accept    = (state == IDLE) && start && !flush;
  assign op_signed = ~op[0];
  assign a_neg     = op_signed & a[XLEN-1];
  assign b_neg     = op_signed & b[XLEN-1];
  assign a_mag     = a_neg ? (~a + 1'b1) : a;
  assign b_mag     = b_neg ? (~b + 1'b1) : b;

  // ---------------------------------------------------------------------------
  // One iteration step
  // ---------------------------------------------------------------------------
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift;
  logic [XLEN-1:0] div_diff;
  logic            div_ge;

  // Shift-add: conditionally add the multiplicand to the upper half, then
  // shift the whole {carry, acc, qr} right by one.
  assign mul_sum   = {1'b0, acc} + (qr[0] ? {1'b0, opnd_b} : '0);

  // Restoring divide: bring in the next dividend bit and subtract if it fits.
  // When it fits the difference is below the divisor, so XLEN bits suffice.
  assign div_shift = {acc, qr[XLEN-1]};
  assign div_ge    = (div_shift >= {1'b0, opnd_b});
  assign div_diff  = div_shift[XLEN-1:0] - opnd_b;

  // ---------------------------------------------------------------------------
  // Sign correction of the finished magnitudes
  // ---------------------------------------------------------------------------
  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   res_hi, res_lo;

  assign prod     = {acc, qr};
  assign prod_fix = neg_q ? (~prod + 1'b1) : prod;
  // A zero divisor yields an all-ones quotient that must reach LO untouched;
  // the remainder path then reproduces the raw dividend on its own.
  assign quo_fix  = (neg_q && !b_zero) ? (~qr + 1'b1) : qr;
  assign rem_fix  = neg_r ? (~acc + 1'b1) : acc;
  assign res_hi   = is_div ? rem_fix : prod_fix[2*XLEN-1:XLEN];
  assign res_lo   = is_div ? quo_fix : prod_fix[XLEN-1:0];

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, otherwise a path
  // that skips the assignment would infer a latch.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = RUN;
      RUN:     if (cnt == LAST_STEP) state_nx = FIX;
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (flush) state_nx = IDLE;
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  assign busy = (state != IDLE);

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: the datapath is cleared on reset as well, so a reset mid-operation
  // leaves no stale partial result behind; these are flops, not a RAM.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      acc    <= '0;
      qr     <= '0;
      opnd_b <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      b_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cnt    <= '0;
            acc    <= '0;
            qr     <= a_mag;
            opnd_b <= b_mag;
            is_div <= op[1];
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            b_zero <= (b == '0);
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (is_div) begin
            acc <= div_ge ? div_diff : div_shift[XLEN-1:0];
            qr  <= {qr[XLEN-2:0], div_ge};
          end else begin
            acc <= mul_sum[XLEN:1];
            qr  <= {mul_sum[0], qr[XLEN-1:1]};
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Architectural HI/LO and completion pulse
  // ---------------------------------------------------------------------------
  // mt writes are accepted only while idle (including the cycle an op is
  // issued); the op result written in FIX later overwrites them.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi   <= '0;
      lo   <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (mt_we[1]) hi <= mt_data;
        if (mt_we[0]) lo <= mt_data;
      end
      if (state == FIX && !flush) begin
        hi   <= res_hi;
        lo   <= res_lo;
        done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// -----------------------------------------------------------------------------
// tb_md_unit -- self-checking bench for md_unit.
//
// Two instances (XLEN=32 and XLEN=8) share the stimulus bus; sel8 chooses which
// one receives start/mt_we and which one's outputs are observed. Expected HI/LO
// come from a reference model using plain 64-bit integer arithmetic.
// -----------------------------------------------------------------------------
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_r;
  logic        flush_r;
  logic        sel8;
  logic [1:0]  op_r;
  logic [1:0]  mt_we_r;
  logic [31:0] a_r, b_r, mt_data_r;

  logic        busy32, done32, busy8, done8;
  logic [31:0] hi32, lo32;
  logic [7:0]  hi8, lo8;

  logic        busy_s, done_s;
  logic [31:0] hi_s, lo_s;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_hi [0:1];
  logic [31:0] exp_lo [0:1];

  always #5 clk = ~clk;

  md_unit #(.XLEN(32), .CNT_W(6)) dut32 (
    .clk     (clk),
    .reset   (reset),
    .start   (start_r & ~sel8),
    .op      (op_r),
    .a       (a_r),
    .b       (b_r),
    .flush   (flush_r),
    .mt_we   (sel8 ? 2'b00 : mt_we_r),
    .mt_data (mt_data_r),
    .busy    (busy32),
    .done    (done32),
    .hi      (hi32),
    .lo      (lo32)
  );

  md_unit #(.XLEN(8), .CNT_W(4)) dut8 (
    .clk     (clk),
    .reset   (reset),
    .start   (start_r & sel8),
    .op      (op_r),
    .a       (a_r[7:0]),
    .b       (b_r[7:0]),
    .flush   (flush_r),
    .mt_we   (sel8 ? mt_we_r : 2'b00),
    .mt_data (mt_data_r[7:0]),
    .busy    (busy8),
    .done    (done8),
    .hi      (hi8),
    .lo      (lo8)
  );

  assign busy_s = sel8 ? busy8 : busy32;
  assign done_s = sel8 ? done8 : done32;
  assign hi_s   = sel8 ? {24'b0, hi8} : hi32;
  assign lo_s   = sel8 ? {24'b0, lo8} : lo32;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] msk(input logic [31:0] x);
    return sel8 ? {24'b0, x[7:0]} : x;
  endfunction

  // Architectural result of an md op for the selected width.
  function automatic void model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] h, output logic [31:0] l);
    logic [31:0] xm, ym;
    longint      sx, sy, q, r;
    logic [63:0] p, ps, qv, rv;
    int          w;
    xm = msk(x);
    ym = msk(y);
    w  = sel8 ? 8 : 32;
    if (!o[0]) begin
      sx = sel8 ? longint'($signed(xm[7:0])) : longint'($signed(xm));
      sy = sel8 ? longint'($signed(ym[7:0])) : longint'($signed(ym));
    end else begin
      sx = longint'(xm);
      sy = longint'(ym);
    end
    if (!o[1]) begin
      p  = sx * sy;
      ps = p >> w;
      h  = msk(ps[31:0]);
      l  = msk(p[31:0]);
    end else if (ym == 32'd0) begin
      l = msk(32'hFFFF_FFFF);
      h = xm;
    end else begin
      q  = sx / sy;
      r  = sx % sy;
      qv = q;
      rv = r;
      l  = msk(qv[31:0]);
      h  = msk(rv[31:0]);
    end
  endfunction

  // Issue one op in the current cycle (cycle 0) and follow it to completion.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [1:0] mt, input logic [31:0] md, input string tag);
    logic [31:0] nh, nl;
    int          c, lat, s;
    bit          busy_ok, hold_ok;
    s   = sel8 ? 1 : 0;
    lat = sel8 ? 10 : 34;
    op_r = o; a_r = x; b_r = y; start_r = 1'b1;
    mt_we_r = mt; mt_data_r = md;
    if (mt[1]) exp_hi[s] = msk(md);
    if (mt[0]) exp_lo[s] = msk(md);
    model(o, x, y, nh, nl);
    tick();
    start_r = 1'b0; mt_we_r = 2'b00;
    c = 1; busy_ok = 1'b1; hold_ok = 1'b1;
    while (!done_s && c < 200) begin
      if (!busy_s) busy_ok = 1'b0;
      if (hi_s !== exp_hi[s] || lo_s !== exp_lo[s]) hold_ok = 1'b0;
      tick();
      c++;
    end
    check({tag, "_done_cycle"}, 64'(c), 64'(lat));
    check({tag, "_busy_run"}, 64'(busy_ok), 64'd1);
    check({tag, "_hold_old"}, 64'(hold_ok), 64'd1);
    check({tag, "_busy_at_done"}, 64'(busy_s), 64'd0);
    exp_hi[s] = nh;
    exp_lo[s] = nl;
    check({tag, "_hi"}, 64'(hi_s), 64'(nh));
    check({tag, "_lo"}, 64'(lo_s), 64'(nl));
    tick();
    check({tag, "_done_pulse"}, 64'(done_s), 64'd0);
  endtask

  task automatic mt_write(input logic [1:0] mt, input logic [31:0] md, input string tag);
    int s;
    s = sel8 ? 1 : 0;
    mt_we_r = mt; mt_data_r = md;
    if (mt[1]) exp_hi[s] = msk(md);
    if (mt[0]) exp_lo[s] = msk(md);
    tick();
    mt_we_r = 2'b00;
    check({tag, "_hi"}, 64'(hi_s), 64'(exp_hi[s]));
    check({tag, "_lo"}, 64'(lo_s), 64'(exp_lo[s]));
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return sel8 ? 32'h80 : 32'h8000_0000;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] fh, fl;
    bit          ok;
    int          c;

    reset = 1'b1; start_r = 1'b0; flush_r = 1'b0; sel8 = 1'b0;
    op_r = 2'b00; mt_we_r = 2'b00; a_r = '0; b_r = '0; mt_data_r = '0;
    exp_hi[0] = '0; exp_lo[0] = '0; exp_hi[1] = '0; exp_lo[1] = '0;
    tick();
    tick();
    check("rst_busy32", 64'(busy32), 64'd0);
    check("rst_done32", 64'(done32), 64'd0);
    check("rst_hi32", 64'(hi32), 64'd0);
    check("rst_lo32", 64'(lo32), 64'd0);
    check("rst_busy8", 64'(busy8), 64'd0);
    check("rst_hilo8", 64'({hi8, lo8}), 64'd0);
    reset = 1'b0;
    tick();

    // Directed cases, 32-bit
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 0, "multu_max");
    check("multu_max_hi_lit", 64'(hi32), 64'hFFFF_FFFE);
    check("multu_max_lo_lit", 64'(lo32), 64'h0000_0001);
    run_op(2'b00, 32'hFFFF_FFFD, 32'd5, 2'b00, 0, "mult_neg");
    check("mult_neg_lo_lit", 64'(lo32), 64'hFFFF_FFF1);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 2'b00, 0, "div_neg");
    check("div_neg_lit", 64'({hi32, lo32}), 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(2'b11, 32'd7, 32'd0, 2'b00, 0, "divu_by0");
    check("divu_by0_lit", 64'({hi32, lo32}), 64'h0000_0007_FFFF_FFFF);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 2'b00, 0, "div_ovf");
    check("div_ovf_lit", 64'({hi32, lo32}), 64'h0000_0000_8000_0000);
    run_op(2'b10, 32'hFFFF_FFF0, 32'd0, 2'b00, 0, "div_by0_neg");
    run_op(2'b01, 32'd3, 32'd4, 2'b11, 32'hCAFE, "mt_with_start");

    // Preload, flush mid-op, then restart
    mt_write(2'b11, 32'h1234, "preload");
    op_r = 2'b11; a_r = 32'd100; b_r = 32'd7; start_r = 1'b1;
    tick();
    start_r = 1'b0;
    ok = 1'b1;
    for (int i = 1; i < 10; i++) begin
      if (done_s || !busy_s) ok = 1'b0;
      tick();
    end
    flush_r = 1'b1;
    tick();
    flush_r = 1'b0;
    check("flush_run_ok", 64'(ok), 64'd1);
    check("flush_busy", 64'(busy32), 64'd0);
    check("flush_done", 64'(done32), 64'd0);
    check("flush_hilo", 64'({hi32, lo32}), 64'h0000_1234_0000_1234);
    tick();
    run_op(2'b11, 32'd100, 32'd7, 2'b00, 0, "divu_after_flush");
    check("divu_after_flush_lit", 64'({hi32, lo32}), 64'h0000_0002_0000_000E);

    // Flush together with start drops the start
    op_r = 2'b01; a_r = 32'd9; b_r = 32'd9; start_r = 1'b1; flush_r = 1'b1;
    tick();
    start_r = 1'b0; flush_r = 1'b0;
    check("flush_start_busy", 64'(busy32), 64'd0);
    tick();
    check("flush_start_busy2", 64'(busy32), 64'd0);

    // Second start and mt write while busy are ignored
    model(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, fh, fl);
    op_r = 2'b01; a_r = 32'h1234_5678; b_r = 32'h9ABC_DEF0; start_r = 1'b1;
    tick();
    start_r = 1'b0;
    c = 1;
    while (!done32 && c < 200) begin
      start_r = (c == 5);
      if (c == 5) begin op_r = 2'b10; a_r = 32'd1000; b_r = 32'd3; end
      mt_we_r = (c == 6) ? 2'b01 : 2'b00;
      mt_data_r = 32'hDEAD;
      tick();
      c++;
    end
    start_r = 1'b0; mt_we_r = 2'b00;
    check("busy_ign_cycle", 64'(c), 64'd34);
    check("busy_ign_result", 64'({hi32, lo32}), 64'({fh, fl}));
    exp_hi[0] = fh; exp_lo[0] = fl;
    tick();
    check("busy_ign_after", 64'(busy32), 64'd0);

    // Reset in cycle 20 of an op
    op_r = 2'b00; a_r = 32'hDEAD_BEEF; b_r = 32'h1234; start_r = 1'b1;
    tick();
    start_r = 1'b0;
    for (int i = 1; i < 20; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_busy", 64'(busy32), 64'd0);
    check("midrst_done", 64'(done32), 64'd0);
    check("midrst_hilo", 64'({hi32, lo32}), 64'd0);
    exp_hi[0] = '0; exp_lo[0] = '0; exp_hi[1] = '0; exp_lo[1] = '0;
    ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (done32 || busy32) ok = 1'b0;
      tick();
    end
    check("midrst_quiet", 64'(ok), 64'd1);

    // Directed cases, 8-bit
    sel8 = 1'b1;
    run_op(2'b01, 32'hFF, 32'hFF, 2'b00, 0, "multu8_max");
    check("multu8_max_lit", 64'({hi8, lo8}), 64'hFE01);
    run_op(2'b10, 32'h80, 32'hFF, 2'b00, 0, "div8_ovf");
    check("div8_ovf_lit", 64'({hi8, lo8}), 64'h0080);

    // Randomized ops on both widths
    for (int i = 0; i < 70; i++) begin
      logic [1:0] mt;
      sel8 = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0)
        mt_write(2'($urandom_range(1, 3)), $urandom, "rnd_mt");
      mt = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      run_op(2'($urandom_range(0, 3)), pick(), pick(), mt, $urandom, "rnd_op");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
